// File: rtl/fsm_prueba_memoria_param.sv
// fsm_prueba_memoria_param: memory self-test engine.
// Writes a pattern to NUM_WORDS words, reads it back, reports mismatches.
module fsm_prueba_memoria_param #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 18,
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar_prueba,
  input  logic [ADDR_W-1:0] direccion_base,
  input  logic [1:0]        modo,
  input  logic              operacion_completada,
  input  logic [DATA_W-1:0] datos_leidos,
  output logic              leer,
  output logic              escribir,
  output logic [DATA_W-1:0] datos_por_escribir,
  output logic [ADDR_W-1:0] direccion_memoria,
  output logic              ocupado,
  output logic              prueba_terminada,
  output logic              prueba_ok,
  output logic [15:0]       conteo_errores,
  output logic [ADDR_W-1:0] primera_dir_error
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_WORDS - 1);
  localparam logic [DATA_W-1:0] UNO = DATA_W'(1);
  localparam logic [DATA_W-1:0] PAR = {(DATA_W/2){2'b10}};
  localparam logic [DATA_W-1:0] IMPAR = {(DATA_W/2){2'b01}};

  typedef enum logic [2:0] {
    REPOSO,
    ESCRIBIR,
    PAUSA_ESC,
    LEER,
    PAUSA_LEC,
    FIN
  } estado_t;

  estado_t estado, estado_sig;
  logic [IDX_W-1:0]  idx, idx_sig;
  logic [ADDR_W-1:0] base;
  logic [1:0]        modo_r;
  logic [ADDR_W-1:0] dir_act;
  logic [DATA_W-1:0] patron;
  logic [15:0]       conteo_sig;
  logic              fallo;

  // Current address (wraps mod 2^ADDR_W) and expected pattern for word idx
  always_comb begin
    dir_act = base + ADDR_W'(idx);
    patron  = '0;
    unique case (modo_r)
      2'd0:    patron = DATA_W'(dir_act);
      2'd1:    patron = ~DATA_W'(dir_act);
      2'd2:    patron = UNO << (32'(idx) % DATA_W);
      default: patron = idx[0] ? IMPAR : PAR;
    endcase
  end

  // Read-back compare and saturating error count
  always_comb begin
    fallo      = (datos_leidos != patron);
    conteo_sig = conteo_errores;
    if (fallo && conteo_errores != 16'hFFFF)
      conteo_sig = conteo_errores + 16'd1;
  end

  // Next state, word index and Moore outputs decoded from registered state
  always_comb begin
    estado_sig         = estado;
    idx_sig            = idx;
    leer               = 1'b0;
    escribir           = 1'b0;
    datos_por_escribir = '0;
    direccion_memoria  = '0;
    ocupado            = 1'b1;
    prueba_terminada   = 1'b0;
    unique case (estado)
      REPOSO: begin
        ocupado = 1'b0;
        if (iniciar_prueba) begin
          idx_sig    = '0;
          estado_sig = ESCRIBIR;
        end
      end
      ESCRIBIR: begin
        escribir           = 1'b1;
        direccion_memoria  = dir_act;
        datos_por_escribir = patron;
        if (operacion_completada) begin
          if (idx == ULTIMO) begin
            idx_sig    = '0;
            estado_sig = PAUSA_LEC;
          end else begin
            idx_sig    = idx + IDX_W'(1);
            estado_sig = PAUSA_ESC;
          end
        end
      end
      PAUSA_ESC: estado_sig = ESCRIBIR;
      LEER: begin
        leer              = 1'b1;
        direccion_memoria = dir_act;
        if (operacion_completada) begin
          if (idx == ULTIMO) begin
            estado_sig = FIN;
          end else begin
            idx_sig    = idx + IDX_W'(1);
            estado_sig = PAUSA_LEC;
          end
        end
      end
      PAUSA_LEC: estado_sig = LEER;
      FIN: begin
        prueba_terminada = 1'b1;
        estado_sig       = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // State and index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= REPOSO;
      idx    <= '0;
    end else begin
      estado <= estado_sig;
      idx    <= idx_sig;
    end
  end

  // Latched test setup and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base              <= '0;
      modo_r            <= '0;
      conteo_errores    <= '0;
      prueba_ok         <= 1'b0;
      primera_dir_error <= '0;
    end else begin
      if (estado == REPOSO && iniciar_prueba) begin
        base              <= direccion_base;
        modo_r            <= modo;
        conteo_errores    <= '0;
        prueba_ok         <= 1'b0;
        primera_dir_error <= '0;
      end
      if (estado == LEER && operacion_completada) begin
        conteo_errores <= conteo_sig;
        if (fallo && conteo_errores == 16'd0)
          primera_dir_error <= dir_act;
        if (idx == ULTIMO)
          prueba_ok <= (conteo_sig == 16'd0);
      end
    end
  end

endmodule
